xbus_drive_seq: RTL and testbench

//  Upstream sequencer for a dual-half tristate bus driver (74S241-style: half A enable active-low, half B active-high).

---
 rtl/xbus_drive_seq.sv | 221 ++++++++++++++++++++++
 tb/tb_xbus_drive_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xbus_drive_seq.sv
// xbus_drive_seq: upstream sequencer for a dual-half tristate bus driver.
// Two requesters (A, B) compete for one shared bus. The winner's data is registered
// onto the matching driver half, and the enables are sequenced so that only one half
// is ever driven. Consecutive grants are separated by a fixed dead time.
// Half A enable is active-low (aenb_n). Half B enable is active-high (benb).
// Optional feature macro: DRV_MONITOR_EN. It adds the sticky err output and aborts a
// grant when its requester drops the request before the last drive cycle.
module xbus_drive_seq #(
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 2,  // 1..15
  parameter int DEAD_CYCLES = 1   // 1..15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             ack_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             ack_b,
  output logic [WIDTH-1:0] dout_a,
  output logic             aenb_n,
  output logic [WIDTH-1:0] dout_b,
  output logic             benb,
  output logic             busy
`ifdef DRV_MONITOR_EN
  ,
  output logic             err
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] DEAD_LOAD = 4'(DEAD_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic             sel_reg, sel_next;     // side being driven: 0 = A, 1 = B
  logic             last_reg, last_next;   // side served most recently
  logic [WIDTH-1:0] dout_a_reg, dout_a_next;
  logic [WIDTH-1:0] dout_b_reg, dout_b_next;
  logic             aenb_n_reg, aenb_n_next;
  logic             benb_reg, benb_next;
  logic             ack_a_reg, ack_a_next;
  logic             ack_b_reg, ack_b_next;
  logic             busy_reg, busy_next;
`ifdef DRV_MONITOR_EN
  logic             err_reg, err_next;
  logic             req_sel;
`endif

  logic any_req;
  logic pick_b;
  logic do_grant;

  // Arbitration. On a tie, the side that was not served last wins, so that
  // continuous requests strictly alternate.
  always_comb begin
    any_req = req_a | req_b;
    pick_b  = (req_a & req_b) ? ~last_reg : req_b;
  end

`ifdef DRV_MONITOR_EN
  // Request line of the side currently holding the bus.
  always_comb begin
    req_sel = sel_reg ? req_b : req_a;
  end
`endif

  // Next-state and next-output logic. Every output is produced as a register next value.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    sel_next    = sel_reg;
    last_next   = last_reg;
    dout_a_next = dout_a_reg;
    dout_b_next = dout_b_reg;
    aenb_n_next = aenb_n_reg;
    benb_next   = benb_reg;
    ack_a_next  = 1'b0;
    ack_b_next  = 1'b0;
    do_grant    = 1'b0;
`ifdef DRV_MONITOR_EN
    err_next    = err_reg;
`endif

    case (state_reg)
      IDLE: begin
        aenb_n_next = 1'b1;
        benb_next   = 1'b0;
        if (any_req) begin
          do_grant = 1'b1;
        end
      end

      DRIVE: begin
        if (cnt_reg == 4'd0) begin
          // Last drive cycle ends here. Release the bus and start the dead time.
          aenb_n_next = 1'b1;
          benb_next   = 1'b0;
          cnt_next    = DEAD_LOAD;
          state_next  = GAP;
        end
`ifdef DRV_MONITOR_EN
        else if (!req_sel) begin
          // The requester withdrew early. Abort without an ack and flag it.
          aenb_n_next = 1'b1;
          benb_next   = 1'b0;
          cnt_next    = DEAD_LOAD;
          state_next  = GAP;
          err_next    = 1'b1;
        end
`endif
        else begin
          cnt_next = cnt_reg - 4'd1;
          // The next cycle will be the last drive cycle, so ack in it.
          if (cnt_reg == 4'd1) begin
            ack_a_next = ~sel_reg;
            ack_b_next = sel_reg;
          end
        end
      end

      GAP: begin
        aenb_n_next = 1'b1;
        benb_next   = 1'b0;
        if (cnt_reg != 4'd0) begin
          cnt_next = cnt_reg - 4'd1;
        end else if (any_req) begin
          do_grant = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end

      default: begin
        aenb_n_next = 1'b1;
        benb_next   = 1'b0;
        state_next  = IDLE;
      end
    endcase

    if (do_grant) begin
      sel_next   = pick_b;
      last_next  = pick_b;
      cnt_next   = HOLD_LOAD;
      state_next = DRIVE;
      if (pick_b) begin
        dout_b_next = data_b;
        benb_next   = 1'b1;
        aenb_n_next = 1'b1;
      end else begin
        dout_a_next = data_a;
        aenb_n_next = 1'b0;
        benb_next   = 1'b0;
      end
      // With a single hold cycle, the first drive cycle is also the last one.
      if (HOLD_CYCLES == 1) begin
        ack_a_next = ~pick_b;
        ack_b_next = pick_b;
      end
    end

    busy_next = (state_next != IDLE);
  end

  // State and output registers. Reset drops both enables immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= 4'd0;
      sel_reg    <= 1'b0;
      last_reg   <= 1'b1;
      dout_a_reg <= '0;
      dout_b_reg <= '0;
      aenb_n_reg <= 1'b1;
      benb_reg   <= 1'b0;
      ack_a_reg  <= 1'b0;
      ack_b_reg  <= 1'b0;
      busy_reg   <= 1'b0;
`ifdef DRV_MONITOR_EN
      err_reg    <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      sel_reg    <= sel_next;
      last_reg   <= last_next;
      dout_a_reg <= dout_a_next;
      dout_b_reg <= dout_b_next;
      aenb_n_reg <= aenb_n_next;
      benb_reg   <= benb_next;
      ack_a_reg  <= ack_a_next;
      ack_b_reg  <= ack_b_next;
      busy_reg   <= busy_next;
`ifdef DRV_MONITOR_EN
      err_reg    <= err_next;
`endif
    end
  end

  // Registered outputs.
  always_comb begin
    ack_a  = ack_a_reg;
    ack_b  = ack_b_reg;
    dout_a = dout_a_reg;
    dout_b = dout_b_reg;
    aenb_n = aenb_n_reg;
    benb   = benb_reg;
    busy   = busy_reg;
`ifdef DRV_MONITOR_EN
    err    = err_reg;
`endif
  end

endmodule

// File: tb/tb_xbus_drive_seq.sv
// Testbench for xbus_drive_seq.
// The main instance uses the default parameters. The second instance uses
// HOLD_CYCLES=1 and DEAD_CYCLES=3.
// Expected grants go into a scoreboard queue when stimulus is issued. A monitor pops
// and compares the queue on every ack pulse.
module tb_xbus_drive_seq;

  logic       clk;
  logic       rst_n;
  logic       req_a, req_b;
  logic [3:0] data_a, data_b;
  logic       ack_a, ack_b;
  logic [3:0] dout_a, dout_b;
  logic       aenb_n, benb, busy;
`ifdef DRV_MONITOR_EN
  logic       err, err4;
`endif

  logic       r4_a, r4_b;
  logic [3:0] d4_a, d4_b;
  logic       k4_a, k4_b;
  logic [3:0] o4_a, o4_b;
  logic       e4_an, e4_b, busy4;

  int n_tests = 0;
  int n_fail  = 0;
  int acks_a  = 0;
  int acks_b  = 0;

  typedef struct packed {
    logic       side;
    logic [3:0] data;
  } exp_t;
  exp_t sb_q[$];

  xbus_drive_seq #(.WIDTH(4), .HOLD_CYCLES(2), .DEAD_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .data_a(data_a), .ack_a(ack_a),
    .req_b(req_b), .data_b(data_b), .ack_b(ack_b),
    .dout_a(dout_a), .aenb_n(aenb_n), .dout_b(dout_b), .benb(benb), .busy(busy)
`ifdef DRV_MONITOR_EN
    , .err(err)
`endif
  );

  xbus_drive_seq #(.WIDTH(4), .HOLD_CYCLES(1), .DEAD_CYCLES(3)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .req_a(r4_a), .data_a(d4_a), .ack_a(k4_a),
    .req_b(r4_b), .data_b(d4_b), .ack_b(k4_b),
    .dout_a(o4_a), .aenb_n(e4_an), .dout_b(o4_b), .benb(e4_b), .busy(busy4)
`ifdef DRV_MONITOR_EN
    , .err(err4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor. It also checks on every cycle that the two enables
  // are never active together.
  always @(negedge clk) begin
    exp_t e;
    n_tests++;
    if (!aenb_n && benb) begin
      n_fail++;
      $display("FAIL overlap: aenb_n=%0b benb=%0b both active", aenb_n, benb);
    end
    n_tests++;
    if (!e4_an && e4_b) begin
      n_fail++;
      $display("FAIL overlap4: aenb_n=%0b benb=%0b both active", e4_an, e4_b);
    end
    if (ack_a || ack_b) begin
      if (ack_a) acks_a++;
      if (ack_b) acks_b++;
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ack: got ack_a=%0b ack_b=%0b expected no ack", ack_a, ack_b);
      end else begin
        logic       g_side;
        logic [3:0] g_data;
        logic       g_en;
        e      = sb_q.pop_front();
        g_side = ack_b;
        g_data = ack_b ? dout_b : dout_a;
        g_en   = ack_b ? benb : ~aenb_n;
        if ((ack_a && ack_b) || g_side != e.side || g_data != e.data || !g_en) begin
          n_fail++;
          $display("FAIL grant: got side=%0d data=%0h en=%0b expected side=%0d data=%0h en=1",
                   g_side, g_data, g_en, e.side, e.data);
        end else begin
          $display("[TB] grant ok side=%s data=%0h", g_side ? "B" : "A", g_data);
        end
      end
    end
  end

  task automatic push_exp(input logic side, input logic [3:0] data);
    exp_t e;
    e.side = side;
    e.data = data;
    sb_q.push_back(e);
  endtask

  // Applies reset for two cycles, checks the reset state, then releases reset at a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_a = 0; req_b = 0; r4_a = 0; r4_b = 0;
    repeat (2) @(negedge clk);
    chk("rst_aenb_n", aenb_n, 1);
    chk("rst_benb", benb, 0);
    chk("rst_dout", {dout_a, dout_b}, 0);
    chk("rst_ack", {ack_a, ack_b}, 0);
    chk("rst_busy", busy, 0);
`ifdef DRV_MONITOR_EN
    chk("rst_err", err, 0);
`endif
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    req_a = 0; req_b = 0; data_a = 0; data_b = 0;
    r4_a = 0; r4_b = 0; d4_a = 0; d4_b = 0;

    // Test 1: a single A request.
    do_reset();
    req_a = 1; data_a = 4'hA; push_exp(1'b0, 4'hA);
    @(negedge clk);
    chk("t1_c1_aenb", aenb_n, 0); chk("t1_c1_dout", dout_a, 4'hA);
    chk("t1_c1_ack", ack_a, 0);   chk("t1_c1_busy", busy, 1);
    @(negedge clk);
    chk("t1_c2_aenb", aenb_n, 0); chk("t1_c2_ack", ack_a, 1);
    req_a = 0;
    @(negedge clk);
    chk("t1_c3_aenb", aenb_n, 1); chk("t1_c3_ack", ack_a, 0); chk("t1_c3_busy", busy, 1);
    @(negedge clk);
    chk("t1_c4_busy", busy, 0);

    // Test 2: A and B request together. A wins after reset, then B follows.
    do_reset();
    req_a = 1; data_a = 4'h5; req_b = 1; data_b = 4'h3;
    push_exp(1'b0, 4'h5); push_exp(1'b1, 4'h3);
    @(negedge clk);
    chk("t2_c1_aenb", aenb_n, 0); chk("t2_c1_benb", benb, 0); chk("t2_c1_dout", dout_a, 4'h5);
    @(negedge clk);
    req_a = 0;
    @(negedge clk);
    chk("t2_c3_gap", {aenb_n, benb}, 2'b10);
    @(negedge clk);
    chk("t2_c4_benb", benb, 1); chk("t2_c4_dout", dout_b, 4'h3); chk("t2_c4_douta", dout_a, 4'h5);
    @(negedge clk);
    chk("t2_c5_benb", benb, 1);
    req_b = 0;
    repeat (2) @(negedge clk);
    chk("t2_idle", busy, 0);

    // Test 3: both requests held for 20 cycles. Grants at edges 0,3,...,18 give A,B,A,B,A,B,A.
    do_reset();
    acks_a = 0; acks_b = 0;
    req_a = 1; req_b = 1; data_a = 4'h1; data_b = 4'h2;
    for (int i = 0; i < 7; i++) push_exp(i[0], (i[0] ? 4'h2 : 4'h1));
    repeat (20) @(negedge clk);
    req_a = 0; req_b = 0;
    repeat (4) @(negedge clk);
    chk("t3_acks_a", acks_a, 4);
    chk("t3_acks_b", acks_b, 3);
    chk("t3_idle", busy, 0);

    // Test 4: HOLD_CYCLES=1 and DEAD_CYCLES=3 on the second instance.
    do_reset();
    r4_a = 1; r4_b = 1; d4_a = 4'h6; d4_b = 4'h9;
    @(negedge clk);
    chk("t4_c1_aenb", e4_an, 0); chk("t4_c1_ack", k4_a, 1); chk("t4_c1_dout", o4_a, 4'h6);
    r4_a = 0;
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      chk("t4_dead", {e4_an, e4_b, k4_a, k4_b}, 4'b1000);
    end
    @(negedge clk);
    chk("t4_c5_benb", e4_b, 1); chk("t4_c5_ack", k4_b, 1); chk("t4_c5_dout", o4_b, 4'h9);
    r4_b = 0;
    @(negedge clk);
    chk("t4_c6_benb", e4_b, 0); chk("t4_c6_ack", k4_b, 0);

    // Test 5: reset asserted during a B grant, then a tie after release.
    do_reset();
    req_b = 1; data_b = 4'h7;
    @(negedge clk);
    chk("t5_c1_benb", benb, 1); chk("t5_c1_dout", dout_b, 4'h7);
    #2 rst_n = 1'b0; req_b = 0;
    #1;
    chk("t5_async_benb", benb, 0); chk("t5_async_dout", dout_b, 0); chk("t5_async_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req_a = 1; req_b = 1; data_a = 4'hC; data_b = 4'hD;
    push_exp(1'b0, 4'hC); push_exp(1'b1, 4'hD);
    @(negedge clk);
    chk("t5_first_a", aenb_n, 0); chk("t5_first_nb", benb, 0);
    @(negedge clk);
    req_a = 0;
    repeat (3) @(negedge clk);
    req_b = 0;
    repeat (2) @(negedge clk);

`ifdef DRV_MONITOR_EN
    // Test 6: A withdraws its request during its first drive cycle.
    do_reset();
    req_a = 1; data_a = 4'hE;
    @(negedge clk);
    chk("t6_c1_aenb", aenb_n, 0);
    req_a = 0;
    @(negedge clk);
    chk("t6_c2_aenb", aenb_n, 1); chk("t6_c2_ack", ack_a, 0); chk("t6_c2_err", err, 1);
    repeat (3) @(negedge clk);
    chk("t6_err_sticky", err, 1);
    do_reset();
`endif

    chk("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
